// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-count receiver: state encoding,
// Gray-to-binary decode and the multi-bit-step test.
package gray_pkg;

    localparam int unsigned MAX_W = 16;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } rx_state_e;

    // Narrower callers zero-extend into MAX_W; leading zeros do not disturb the XOR prefix.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // True when two or more bits are set, i.e. clearing the lowest set bit leaves a nonzero value.
    function automatic logic popcount_gt1(input logic [MAX_W-1:0] diff);
        return (diff & (diff - MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_count_receiver_sync.sv
// Multi-flop synchronizer for a Gray-coded bus; nothing sits ahead of the first stage.
module gray_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_count_receiver.sv
// Receives a Gray count from a foreign domain, decodes it, reports per-sample
// increments and flags illegal multi-bit steps once the sync chain is primed.
module gray_count_receiver
    import gray_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] gray_in,
    input  logic                     clear_in,
    output logic [COUNTER_WIDTH-1:0] binary_out,
    output logic [COUNTER_WIDTH-1:0] delta_out,
    output logic                     delta_valid_out,
    output logic                     step_error_out,
    output logic                     sticky_error_out,
    output logic [ERR_CNT_WIDTH-1:0] error_count_out,
    output logic                     tracking_out
);

    localparam int unsigned PCW = $clog2(SYNC_STAGES + 1);

    logic [COUNTER_WIDTH-1:0] w_sync_q;
    logic [COUNTER_WIDTH-1:0] w_bin_next;
    logic                     w_illegal;

    logic [COUNTER_WIDTH-1:0] r_prev_gray;
    logic [COUNTER_WIDTH-1:0] r_binary;
    logic [COUNTER_WIDTH-1:0] r_delta;
    logic                     r_delta_valid;
    rx_state_e                r_state;
    logic [PCW-1:0]           r_prime_cnt;
    logic                     r_step_err;
    logic                     r_sticky;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic                     r_tracking;

    gray_sync #(
        .WIDTH  (COUNTER_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (gray_in),
        .o_q   (w_sync_q)
    );

    always_comb begin
        w_bin_next = COUNTER_WIDTH'(gray2bin(MAX_W'(w_sync_q)));
        w_illegal  = popcount_gt1(MAX_W'(w_sync_q ^ r_prev_gray));
    end

    // Decode path runs every cycle regardless of FSM state or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_gray   <= '0;
            r_binary      <= '0;
            r_delta       <= '0;
            r_delta_valid <= 1'b0;
        end else begin
            r_prev_gray   <= w_sync_q;
            r_binary      <= w_bin_next;
            r_delta       <= w_bin_next - r_binary;
            r_delta_valid <= (w_bin_next != r_binary);
        end
    end

    // PRIME holds off error checks until the sync chain has flushed stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PRIME;
            r_prime_cnt <= '0;
            r_step_err  <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_cnt   <= '0;
            r_tracking  <= 1'b0;
        end else if (clear_in) begin
            r_state     <= PRIME;
            r_prime_cnt <= '0;
            r_step_err  <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_cnt   <= '0;
            r_tracking  <= 1'b0;
        end else begin
            case (r_state)
                PRIME: begin
                    r_step_err <= 1'b0;
                    if (r_prime_cnt == PCW'(SYNC_STAGES)) begin
                        r_state    <= TRACK;
                        r_tracking <= 1'b1;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + PCW'(1);
                    end
                end
                TRACK: begin
                    r_tracking <= 1'b1;
                    r_step_err <= w_illegal;
                    if (w_illegal) begin
                        r_sticky <= 1'b1;
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= PRIME;
                    r_step_err <= 1'b0;
                    r_tracking <= 1'b0;
                end
            endcase
        end
    end

    assign binary_out       = r_binary;
    assign delta_out        = r_delta;
    assign delta_valid_out  = r_delta_valid;
    assign step_error_out   = r_step_err;
    assign sticky_error_out = r_sticky;
    assign error_count_out  = r_err_cnt;
    assign tracking_out     = r_tracking;

endmodule

// File: tb/tb_gray_count_receiver.sv
// Directed bench for gray_count_receiver (width 4, two sync stages, 8-bit error count).
module tb_gray_count_receiver;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       clear_in;
    logic [3:0] binary_out;
    logic [3:0] delta_out;
    logic       delta_valid_out;
    logic       step_error_out;
    logic       sticky_error_out;
    logic [7:0] error_count_out;
    logic       tracking_out;

    int checks;
    int failures;

    gray_count_receiver #(
        .COUNTER_WIDTH (4),
        .SYNC_STAGES   (2),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gray_in          (gray_in),
        .clear_in         (clear_in),
        .binary_out       (binary_out),
        .delta_out        (delta_out),
        .delta_valid_out  (delta_valid_out),
        .step_error_out   (step_error_out),
        .sticky_error_out (sticky_error_out),
        .error_count_out  (error_count_out),
        .tracking_out     (tracking_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gray;
        logic       clr;
        logic [3:0] bin;
        logic [3:0] dlt;
        logic       dv;
        logic       stp;
        logic       sty;
        logic [7:0] cnt;
        logic       trk;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] g, input logic c, input logic [3:0] b,
                                input logic [3:0] d, input logic dv, input logic s,
                                input logic sy, input logic [7:0] n, input logic t);
        vec_t v;
        v.gray = g; v.clr = c; v.bin = b; v.dlt = d; v.dv = dv;
        v.stp = s; v.sty = sy; v.cnt = n; v.trk = t;
        return v;
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [%0d] got=%0h expected=%0h", name, tag, got, exp);
        end
    endtask

    task automatic check_all(input string name, input int tag, input logic [3:0] b,
                             input logic [3:0] d, input logic dv, input logic s,
                             input logic sy, input logic [7:0] n, input logic t);
        check({name, ".binary"}, tag, 32'(binary_out), 32'(b));
        check({name, ".delta"}, tag, 32'(delta_out), 32'(d));
        check({name, ".delta_valid"}, tag, 32'(delta_valid_out), 32'(dv));
        check({name, ".step_err"}, tag, 32'(step_error_out), 32'(s));
        check({name, ".sticky"}, tag, 32'(sticky_error_out), 32'(sy));
        check({name, ".err_cnt"}, tag, 32'(error_count_out), 32'(n));
        check({name, ".tracking"}, tag, 32'(tracking_out), 32'(t));
    endtask

    // One active edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        gray_in  = 4'h0;
        clear_in = 1'b0;

        // Rows: inputs applied before an edge, expectations sampled after it.
        vecs[0]  = mk(4'b0000, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 0);
        vecs[1]  = mk(4'b0000, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 0);
        vecs[2]  = mk(4'b0000, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[3]  = mk(4'b0000, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[4]  = mk(4'b0000, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[5]  = mk(4'b0001, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[6]  = mk(4'b0011, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[7]  = mk(4'b0010, 0, 4'd1,  4'd1,  1, 0, 0, 8'd0, 1);
        vecs[8]  = mk(4'b0110, 0, 4'd2,  4'd1,  1, 0, 0, 8'd0, 1);
        vecs[9]  = mk(4'b0110, 0, 4'd3,  4'd1,  1, 0, 0, 8'd0, 1);
        vecs[10] = mk(4'b0110, 0, 4'd4,  4'd1,  1, 0, 0, 8'd0, 1);
        vecs[11] = mk(4'b0110, 0, 4'd4,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[12] = mk(4'b1000, 1, 4'd4,  4'd0,  0, 0, 0, 8'd0, 0);
        vecs[13] = mk(4'b1000, 0, 4'd4,  4'd0,  0, 0, 0, 8'd0, 0);
        vecs[14] = mk(4'b1000, 0, 4'd15, 4'd11, 1, 0, 0, 8'd0, 0);
        vecs[15] = mk(4'b1000, 0, 4'd15, 4'd0,  0, 0, 0, 8'd0, 1);
        vecs[16] = mk(4'b0000, 0, 4'd15, 4'd0,  0, 0, 0, 8'd0, 1);
        vecs[17] = mk(4'b0000, 0, 4'd15, 4'd0,  0, 0, 0, 8'd0, 1);
        vecs[18] = mk(4'b0101, 0, 4'd0,  4'd1,  1, 0, 0, 8'd0, 1);
        vecs[19] = mk(4'b0101, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0, 1);
        vecs[20] = mk(4'b0101, 0, 4'd6,  4'd6,  1, 1, 1, 8'd1, 1);
        vecs[21] = mk(4'b0101, 0, 4'd6,  4'd0,  0, 0, 1, 8'd1, 1);
        vecs[22] = mk(4'b0101, 0, 4'd6,  4'd0,  0, 0, 1, 8'd1, 1);

        #3;
        check_all("reset", 0, 4'd0, 4'd0, 0, 0, 0, 8'd0, 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            gray_in  = vecs[i].gray;
            clear_in = vecs[i].clr;
            tick();
            check_all("vec", i, vecs[i].bin, vecs[i].dlt, vecs[i].dv, vecs[i].stp,
                      vecs[i].sty, vecs[i].cnt, vecs[i].trk);
        end
        clear_in = 1'b0;

        // Clear arrives in the same cycle an illegal step sits on sync_q: clear wins.
        gray_in = 4'b0000;
        tick();
        tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check_all("clr_vs_err", 0, 4'd0, 4'd10, 1, 0, 0, 8'd0, 0);
        tick();
        check_all("clr_prime", 1, 4'd0, 4'd0, 0, 0, 0, 8'd0, 0);
        tick();
        check_all("clr_prime", 2, 4'd0, 4'd0, 0, 0, 0, 8'd0, 0);
        tick();
        check_all("clr_prime", 3, 4'd0, 4'd0, 0, 0, 0, 8'd0, 1);

        // Back-to-back 2-bit jumps; counter must stop at all-ones.
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 4'b0101 : 4'b0000;
            tick();
            if (i == 9) begin
                check("sat_mid.err_cnt", i, 32'(error_count_out), 32'd8);
                check("sat_mid.step_err", i, 32'(step_error_out), 32'd1);
            end
        end
        tick();
        tick();
        tick();
        check("sat.err_cnt", 0, 32'(error_count_out), 32'd255);
        check("sat.sticky", 0, 32'(sticky_error_out), 32'd1);
        check("sat.step_idle", 0, 32'(step_error_out), 32'd0);
        check("sat.binary", 0, 32'(binary_out), 32'd0);

        // Async reset between edges, then re-prime with a nonzero input.
        gray_in = 4'b0001;
        tick();
        tick();
        tick();
        check("pre_rst.binary", 0, 32'(binary_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 4'd0, 4'd0, 0, 0, 0, 8'd0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_all("rerun", 1, 4'd0, 4'd0, 0, 0, 0, 8'd0, 0);
        tick();
        check_all("rerun", 2, 4'd0, 4'd0, 0, 0, 0, 8'd0, 0);
        tick();
        check_all("rerun", 3, 4'd1, 4'd1, 1, 0, 0, 8'd0, 1);
        tick();
        check_all("rerun", 4, 4'd1, 4'd0, 0, 0, 0, 8'd0, 1);
        gray_in = 4'b0011;
        tick();
        tick();
        tick();
        check_all("rerun", 5, 4'd2, 4'd1, 1, 0, 0, 8'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
